spi_flash_reader: RTL

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_reader.sv
// SPI NOR read engine: sends a read opcode, address and dummy cycles (mode 0),
// then streams received bytes through a valid/ready register.
module spi_flash_reader #(
  parameter int unsigned ADDR_W = 24,
  parameter logic [7:0]  CMD    = 8'h03,
  parameter int unsigned DUMMY  = 0,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned DIV    = 1,
  parameter int unsigned CS_HI  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_start,
  input  logic [ADDR_W-1:0] IN_addr,
  input  logic [LEN_W-1:0]  IN_len,
  input  logic              IN_cancel,
  output logic              OUT_busy,
  output logic [7:0]        OUT_data,
  output logic              OUT_dataValid,
  input  logic              IN_dataReady,
  output logic              OUT_done,
  output logic              OUT_sclk,
  output logic              OUT_cs,
  output logic              OUT_mosi,
  input  logic              IN_miso
);

  localparam int unsigned DivW = $clog2(DIV + 1);
  localparam int unsigned EndW = $clog2(CS_HI + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StHold, StEnd} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic              hi_q, hi_d;
  logic [5:0]        bit_q, bit_d;
  logic [39:0]       sh_q, sh_d;
  logic [7:0]        rx_q, rx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [EndW-1:0]   end_q, end_d;
  logic              sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  logic [31:0] addr_al;
  logic        phase_end, bit_last, free, load_byte;

  // Opcode and address share one shifter; zeros shift in behind them for dummy/data.
  assign addr_al   = 32'(IN_addr) << (32 - ADDR_W);
  assign phase_end = (div_q == DivW'(DIV - 1));
  assign free      = !valid_q || IN_dataReady;

  always_comb begin
    bit_last = 1'b0;
    case (state_q)
      StCmd:   bit_last = (bit_q == 6'd7);
      StAddr:  bit_last = (bit_q == 6'(ADDR_W - 1));
      StDummy: bit_last = (bit_q == 6'(DUMMY - 1));
      StData:  bit_last = (bit_q == 6'd7);
      default: bit_last = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    hi_d      = hi_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    len_d     = len_q;
    end_d     = end_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load_byte = 1'b0;

    if (valid_q && IN_dataReady) valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (IN_start && (IN_len != '0)) begin
          state_d = StCmd;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          len_d   = IN_len;
          sh_d    = {CMD, addr_al};
          mosi_d  = CMD[7];
          div_d   = '0;
          hi_d    = 1'b0;
          bit_d   = '0;
        end
      end
      StCmd, StAddr, StDummy, StData: begin
        div_d = phase_end ? '0 : div_q + 1'b1;
        if (phase_end && !hi_q) begin
          hi_d   = 1'b1;
          sclk_d = 1'b1;
          if (state_q == StData) rx_d = {rx_q[6:0], IN_miso};
        end else if (phase_end && hi_q) begin
          hi_d   = 1'b0;
          sclk_d = 1'b0;
          sh_d   = sh_q << 1;
          mosi_d = sh_q[38];
          bit_d  = bit_last ? '0 : bit_q + 1'b1;
          if (bit_last) begin
            case (state_q)
              StCmd:   state_d = StAddr;
              StAddr:  state_d = (DUMMY == 0) ? StData : StDummy;
              StDummy: state_d = StData;
              default: load_byte = 1'b1;
            endcase
          end
        end
      end
      StHold: load_byte = 1'b1;
      StEnd: begin
        if (end_q == EndW'(CS_HI - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          end_d = end_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // A finished byte waits in rx_q with SCLK parked low until the output register frees.
    if (load_byte) begin
      if (free) begin
        data_d  = rx_q;
        valid_d = 1'b1;
        len_d   = len_q - 1'b1;
        div_d   = '0;
        hi_d    = 1'b0;
        if (len_q == LEN_W'(1)) begin
          state_d = StEnd;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          end_d   = '0;
        end else begin
          state_d = StData;
        end
      end else begin
        state_d = StHold;
      end
    end

    if (IN_cancel && (state_q inside {StCmd, StAddr, StDummy, StData, StHold})) begin
      state_d = StEnd;
      cs_d    = 1'b1;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
      end_d   = '0;
      len_d   = '0;
      data_d  = data_q;
      valid_d = valid_q && !IN_dataReady;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      div_q   <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      len_q   <= '0;
      end_q   <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      len_q   <= len_d;
      end_q   <= end_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign OUT_busy      = busy_q;
  assign OUT_data      = data_q;
  assign OUT_dataValid = valid_q;
  assign OUT_done      = done_q;
  assign OUT_sclk      = sclk_q;
  assign OUT_cs        = cs_q;
  assign OUT_mosi      = mosi_q;

endmodule
